auth_req_arbiter: RTL and testbench
===================================

AUTH_REQ_ARBITER -- requirements
Module: auth_req_arbiter

Interface
REQ-001 Parameter UID_W, default 128, SHALL set the width of each flattened UID field (16 bytes).
REQ-002 Parameter STAT_W, default 16, SHALL set the width of each statistics counter.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_valid  input  2  SHALL flag a request per port; port 0 is the reader, port 1 is the admin.
REQ-006 req_ready  output  2  SHALL flag request acceptance per port.
REQ-007 req_cmd  input  2x8 (flat)  SHALL carry the command per port.
REQ-008 req_uid_flat  input  2xUID_W (flat)  SHALL carry the UID bytes per port.
REQ-009 req_uid_len  input  2x8 (flat)  SHALL carry the UID length per port.
REQ-010 rsp_valid  output  2  SHALL flag a response per port.
REQ-011 rsp_ready  input  2  SHALL flag response acceptance per port.
REQ-012 rsp_code  output  3  SHALL carry the response code, shared by both ports.
REQ-013 lut_valid, lut_cmd[7:0], lut_uid_flat[UID_W-1:0], lut_uid_len[7:0]  output  SHALL drive the UID lookup table.
REQ-014 lut_allowed, lut_added_ok, lut_duplicate, lut_full  input  1 each  SHALL be the table results, registered one clock after lut_valid.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-016 IDLE: the round-robin winner among asserted req_valid SHALL see req_ready high combinationally; the other port SHALL see req_ready low.
REQ-017 On accept, the block SHALL latch port id, cmd, uid and len.
  - If the command is legal, the FSM SHALL go to ISSUE.
  - Otherwise, the FSM SHALL go directly to RESP with code BADCMD.
REQ-018 Legal commands SHALL be:
  - port 0: CHECK (0x10) only;
  - port 1: CHECK (0x10) and ADD (0x11).
REQ-019 ISSUE: lut_valid SHALL be high for exactly one cycle with the latched fields, then the FSM SHALL go to WAIT.
REQ-020 WAIT: table outputs SHALL be sampled at the end of the cycle and mapped to a code, then the FSM SHALL go to RESP.
  - CHECK: ALLOWED(1) if lut_allowed, else DENIED(0).
  - ADD priority: FULL(4) > DUPLICATE(3) > ADDED(2); if no flag is set, DENIED(0).
REQ-021 RESP: rsp_valid SHALL be high only for the latched port, with rsp_code stable, until rsp_ready for that port; the FSM SHALL then return to IDLE.
REQ-022 lut_cmd, lut_uid_flat and lut_uid_len SHALL hold their latched values outside ISSUE; lut_valid SHALL be 0 outside ISSUE.
REQ-023 Latency SHALL be 3 cycles from accept edge to rsp_valid for legal commands and 1 cycle for BADCMD(5).
REQ-024 Round-robin: after a grant to port k, port k SHALL have lowest priority; if only one port requests, it SHALL win regardless of priority.
REQ-025 At most one request SHALL be outstanding; req_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-026 A req_valid deassertion by a non-granted port SHALL have no effect.

Reset
REQ-027 Reset SHALL force:
  - state IDLE, port 0 highest priority;
  - req_ready=0, rsp_valid=0, rsp_code=0;
  - lut_valid=0, lut_cmd=0, lut_uid_flat=0, lut_uid_len=0;
  - all counters to 0.
REQ-028 Reset mid-transaction SHALL discard the transaction, with no response issued after reset release.

Configuration
REQ-029 With AUTH_ARB_STATS_EN defined, the block SHALL add outputs stat_allowed, stat_denied and stat_badcmd, each STAT_W bits.
  - Each counter SHALL be saturating and increment on the RESP-to-IDLE handshake with the matching code.
  - DENIED and FULL SHALL both count toward stat_denied.
REQ-030 Without AUTH_ARB_STATS_EN, these ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-031 Package auth_pkg SHALL hold:
  - CMD_CHECK_UID=8'h10 and CMD_ADD_UID=8'h11;
  - the rsp_code enum (DENIED=0, ALLOWED=1, ADDED=2, DUPLICATE=3, FULL=4, BADCMD=5);
  - the arbiter state enum.
REQ-032 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant with a priority pointer that updates on accept.

Verification
REQ-033 Port 1 ADD uid 0xDEADBEEF, then port 0 CHECK of the same uid -> port 1 gets ADDED(2) at accept+3 cycles, then port 0 gets ALLOWED(1).
REQ-034 Both ports request CHECK in the same cycle after reset -> port 0 is granted first, port 1 next; on the next simultaneous pair, port 1 is granted first.
REQ-035 Port 0 ADD 0x11 -> BADCMD(5) one cycle after accept; lut_valid never asserts.
REQ-036 Four distinct ADDs, a fifth ADD, and a repeat ADD on a table holding 4 entries -> FULL(4), FULL(4); an ADD of an existing uid on a non-full table -> DUPLICATE(3).
REQ-037 rsp_ready held low for 5 cycles -> rsp_valid and rsp_code stay stable and the other port's req_ready stays 0.
REQ-038 rst_n pulsed low during WAIT -> all outputs return to reset values and no rsp_valid is seen after release; with AUTH_ARB_STATS_EN, counters read 0.

Source files
------------

// File: rtl/auth_req_arbiter_pkg.sv
// auth_pkg: shared command codes, response codes and arbiter state encoding
// for the UID authorisation request arbiter.
package auth_pkg;

    localparam logic [7:0] CMD_CHECK_UID = 8'h10;
    localparam logic [7:0] CMD_ADD_UID   = 8'h11;

    typedef enum logic [2:0] {
        RSP_DENIED    = 3'd0,
        RSP_ALLOWED   = 3'd1,
        RSP_ADDED     = 3'd2,
        RSP_DUPLICATE = 3'd3,
        RSP_FULL      = 3'd4,
        RSP_BADCMD    = 3'd5
    } rsp_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Port 0 (reader) may only check; port 1 (admin) may check or add.
    function automatic logic cmd_legal(input logic port, input logic [7:0] cmd);
        return (cmd == CMD_CHECK_UID) || (port && cmd == CMD_ADD_UID);
    endfunction

endpackage

// File: rtl/auth_req_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a priority pointer.
//   clk, rst_n  clock, asynchronous active-low reset (port 0 favoured)
//   i_req       request per port
//   i_accept    the current grant was taken; pointer moves past the winner
//   o_gnt       one-hot grant among the requesting ports
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    // r_prio names the port that wins a tie
    logic r_prio;

    assign o_gnt[0] = i_req[0] & (~i_req[1] | ~r_prio);
    assign o_gnt[1] = i_req[1] & (~i_req[0] |  r_prio);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_prio <= 1'b0;
        else if (i_accept)
            r_prio <= o_gnt[0];
    end

endmodule

// File: rtl/auth_req_arbiter.sv
// auth_req_arbiter: arbitrates reader (port 0) and admin (port 1) UID
// requests onto a single lookup table, one transaction at a time.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_*                 per-port request handshake and payload (flat 2x)
//   rsp_valid/rsp_ready   per-port response handshake; rsp_code shared
//   lut_*                 lookup-table command out, registered results in
//   stat_*                saturating counters, present only when the macro
//                         AUTH_ARB_STATS_EN is defined
module auth_req_arbiter
    import auth_pkg::*;
#(
    parameter int UID_W  = 128,
    parameter int STAT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [15:0]          req_cmd,
    input  logic [2*UID_W-1:0]   req_uid_flat,
    input  logic [15:0]          req_uid_len,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [2:0]           rsp_code,
    output logic                 lut_valid,
    output logic [7:0]           lut_cmd,
    output logic [UID_W-1:0]     lut_uid_flat,
    output logic [7:0]           lut_uid_len,
    input  logic                 lut_allowed,
    input  logic                 lut_added_ok,
    input  logic                 lut_duplicate,
    input  logic                 lut_full
`ifdef AUTH_ARB_STATS_EN
   ,output logic [STAT_W-1:0]    stat_allowed,
    output logic [STAT_W-1:0]    stat_denied,
    output logic [STAT_W-1:0]    stat_badcmd
`endif
);

    arb_state_e        r_state;
    rsp_code_e         r_code;
    rsp_code_e         w_lut_code;
    logic              r_run;
    logic              r_port;
    logic [7:0]        r_cmd;
    logic [UID_W-1:0]  r_uid;
    logic [7:0]        r_len;
    logic [1:0]        w_gnt;
    logic              w_accept;
    logic              w_port;
    logic [7:0]        w_cmd;
    logic              w_rsp_done;

    rr_arb2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req_valid),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    // r_run keeps req_ready low while reset is asserted even though the
    // FSM already sits in IDLE.
    assign req_ready  = (r_run && r_state == ST_IDLE) ? w_gnt : 2'b00;
    assign w_accept   = |req_ready;
    assign w_port     = w_gnt[1];
    assign w_cmd      = w_port ? req_cmd[15:8] : req_cmd[7:0];
    assign rsp_valid  = (r_state == ST_RESP) ? (r_port ? 2'b10 : 2'b01) : 2'b00;
    assign w_rsp_done = |(rsp_valid & rsp_ready);
    assign rsp_code   = r_code;

    assign lut_valid    = r_state == ST_ISSUE;
    assign lut_cmd      = r_cmd;
    assign lut_uid_flat = r_uid;
    assign lut_uid_len  = r_len;

    // ADD flags resolve with FULL over DUPLICATE over ADDED
    always_comb begin
        w_lut_code = RSP_DENIED;
        if (r_cmd == CMD_CHECK_UID)
            w_lut_code = lut_allowed ? RSP_ALLOWED : RSP_DENIED;
        else
            w_lut_code = lut_full      ? RSP_FULL :
                         lut_duplicate ? RSP_DUPLICATE :
                         lut_added_ok  ? RSP_ADDED : RSP_DENIED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_code  <= RSP_DENIED;
            r_run   <= 1'b0;
            r_port  <= 1'b0;
            r_cmd   <= '0;
            r_uid   <= '0;
            r_len   <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_port <= w_port;
                    r_cmd  <= w_cmd;
                    r_uid  <= w_port ? req_uid_flat[2*UID_W-1 -: UID_W] : req_uid_flat[UID_W-1:0];
                    r_len  <= w_port ? req_uid_len[15:8] : req_uid_len[7:0];
                    if (cmd_legal(w_port, w_cmd))
                        r_state <= ST_ISSUE;
                    else begin
                        r_state <= ST_RESP;
                        r_code  <= RSP_BADCMD;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    r_code  <= w_lut_code;
                    r_state <= ST_RESP;
                end
                default: if (w_rsp_done) r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef AUTH_ARB_STATS_EN
    // Counters tick on the response handshake; FULL counts as a denial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_allowed <= '0;
            stat_denied  <= '0;
            stat_badcmd  <= '0;
        end else if (w_rsp_done) begin
            if (r_code == RSP_ALLOWED && stat_allowed != '1)
                stat_allowed <= stat_allowed + STAT_W'(1);
            if ((r_code == RSP_DENIED || r_code == RSP_FULL) && stat_denied != '1)
                stat_denied <= stat_denied + STAT_W'(1);
            if (r_code == RSP_BADCMD && stat_badcmd != '1)
                stat_badcmd <= stat_badcmd + STAT_W'(1);
        end
    end
`else
    // STAT_W only shapes the optional counters
    if (STAT_W < 1) begin : g_stat_w_unused
    end
`endif

endmodule

// File: tb/tb_auth_req_arbiter.sv
// tb_auth_req_arbiter: scoreboard bench for auth_req_arbiter with a
// 4-entry behavioural lookup table answering one clock after lut_valid.
module tb_auth_req_arbiter;
    import auth_pkg::*;

    localparam int UID_W = 128;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         req_valid = '0;
    logic [1:0]         req_ready;
    logic [15:0]        req_cmd = '0;
    logic [2*UID_W-1:0] req_uid_flat = '0;
    logic [15:0]        req_uid_len = '0;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready = '0;
    logic [2:0]         rsp_code;
    logic               lut_valid;
    logic [7:0]         lut_cmd;
    logic [UID_W-1:0]   lut_uid_flat;
    logic [7:0]         lut_uid_len;
    logic               lut_allowed = 1'b0;
    logic               lut_added_ok = 1'b0;
    logic               lut_duplicate = 1'b0;
    logic               lut_full = 1'b0;
`ifdef AUTH_ARB_STATS_EN
    logic [15:0]        stat_allowed, stat_denied, stat_badcmd;
`endif

    int errors = 0;
    int checks = 0;
    int lv_cnt = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    auth_req_arbiter #(.UID_W(UID_W), .STAT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_uid_flat  (req_uid_flat),
        .req_uid_len   (req_uid_len),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_code      (rsp_code),
        .lut_valid     (lut_valid),
        .lut_cmd       (lut_cmd),
        .lut_uid_flat  (lut_uid_flat),
        .lut_uid_len   (lut_uid_len),
        .lut_allowed   (lut_allowed),
        .lut_added_ok  (lut_added_ok),
        .lut_duplicate (lut_duplicate),
        .lut_full      (lut_full)
`ifdef AUTH_ARB_STATS_EN
       ,.stat_allowed  (stat_allowed),
        .stat_denied   (stat_denied),
        .stat_badcmd   (stat_badcmd)
`endif
    );

    // Behavioural UID table: flags are registered one clock after lut_valid.
    logic [UID_W-1:0] tbl [4];
    int tcnt = 0;
    always @(posedge clk) begin
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i < tcnt && tbl[i] == lut_uid_flat) found = 1'b1;
        lut_allowed   <= 1'b0;
        lut_added_ok  <= 1'b0;
        lut_duplicate <= 1'b0;
        lut_full      <= 1'b0;
        if (lut_valid) begin
            if (lut_cmd == CMD_CHECK_UID)
                lut_allowed <= found;
            else begin
                lut_duplicate <= found;
                lut_full      <= (tcnt == 4);
                if (!found && tcnt < 4) begin
                    tbl[tcnt]    <= lut_uid_flat;
                    tcnt         <= tcnt + 1;
                    lut_added_ok <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) if (lut_valid) lv_cnt++;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic [7:0] cmd, input logic [127:0] uid, input logic [7:0] len);
        req_valid[p] = 1'b1;
        req_cmd[p*8 +: 8] = cmd;
        req_uid_flat[p*UID_W +: UID_W] = uid;
        req_uid_len[p*8 +: 8] = len;
    endtask

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    // Called just after the accept edge; pops the expected response.
    task automatic finish_rsp(input int p, input int lat_exp, input int lv_exp, input int stall);
        int lat = 0;
        int lv0 = lv_cnt;
        logic [3:0] e;
        logic [2:0] code0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[p] && lat < 10);
        check("latency", lat, lat_exp);
        check("lut_cycles", lv_cnt - lv0, lv_exp);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            e = 4'h0;
        end else
            e = sb.pop_front();
        check("rsp_valid", rsp_valid, onehot(e[3]));
        check("rsp_code", rsp_code, e[2:0]);
        code0 = rsp_code;
        if (stall > 0) drive(1 - p, CMD_CHECK_UID, 128'h77, 8'd4);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, onehot(e[3]));
            check("hold_code", rsp_code, code0);
            check("other_ready", req_ready, 2'b00);
        end
        if (stall > 0) req_valid[1 - p] = 1'b0;
        rsp_ready[p] = 1'b1;
        @(negedge clk);
        rsp_ready[p] = 1'b0;
        check("idle_after", rsp_valid, 2'b00);
    endtask

    task automatic transact(input int p, input logic [7:0] cmd, input logic [127:0] uid,
                            input logic [2:0] code, input int stall);
        int n = 0;
        sb.push_back({p[0], code});
        drive(p, cmd, uid, 8'd4);
        #1;
        while (!req_ready[p] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("ready", req_ready[p], 1'b1);
        @(posedge clk);
        #1 req_valid[p] = 1'b0;
        finish_rsp(p, code == RSP_BADCMD ? 1 : 3, code == RSP_BADCMD ? 0 : 1, stall);
    endtask

    // Both ports raise CHECK together; `first` is the port expected to win.
    task automatic pair(input logic first);
        drive(0, CMD_CHECK_UID, 128'h1234, 8'd4);
        drive(1, CMD_CHECK_UID, 128'h1234, 8'd4);
        #1;
        sb.push_back({first, RSP_DENIED});
        check("gnt_first", req_ready, onehot(first));
        @(posedge clk);
        #1 req_valid[first] = 1'b0;
        finish_rsp(int'(first), 3, 1, 0);
        #1;
        sb.push_back({~first, RSP_DENIED});
        check("gnt_second", req_ready, onehot(~first));
        @(posedge clk);
        #1 req_valid[~first] = 1'b0;
        finish_rsp(int'(~first), 3, 1, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_code", rsp_code, 3'd0);
        check("rst_lut_valid", lut_valid, 1'b0);
        check("rst_lut_cmd", lut_cmd, 8'd0);
        check("rst_lut_uid", lut_uid_flat, '0);
        check("rst_lut_len", lut_uid_len, 8'd0);
`ifdef AUTH_ARB_STATS_EN
        check("rst_stat_allowed", stat_allowed, 16'd0);
        check("rst_stat_denied", stat_denied, 16'd0);
        check("rst_stat_badcmd", stat_badcmd, 16'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        req_valid = 2'b00;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        pair(1'b0);
        transact(0, CMD_CHECK_UID, 128'h1234, RSP_DENIED, 0);
        pair(1'b1);

        transact(1, CMD_ADD_UID, 128'hDEADBEEF, RSP_ADDED, 0);
        transact(0, CMD_CHECK_UID, 128'hDEADBEEF, RSP_ALLOWED, 0);
        transact(0, CMD_ADD_UID, 128'hA0, RSP_BADCMD, 0);
        transact(1, 8'h22, 128'hA0, RSP_BADCMD, 0);

        transact(1, CMD_ADD_UID, 128'hDEADBEEF, RSP_DUPLICATE, 0);
        transact(1, CMD_ADD_UID, 128'hA1, RSP_ADDED, 0);
        transact(1, CMD_ADD_UID, 128'hA2, RSP_ADDED, 0);
        transact(1, CMD_ADD_UID, 128'hA3, RSP_ADDED, 0);
        transact(1, CMD_ADD_UID, 128'hA4, RSP_FULL, 0);
        transact(1, CMD_ADD_UID, 128'hDEADBEEF, RSP_FULL, 0);
        transact(0, CMD_CHECK_UID, 128'hA4, RSP_DENIED, 0);

        transact(0, CMD_CHECK_UID, 128'hA3, RSP_ALLOWED, 5);

        // Reset while the table lookup is in flight
        drive(0, CMD_CHECK_UID, 128'hA2, 8'd4);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("in_wait_no_rsp", rsp_valid, 2'b00);
        rst_n = 1'b0;
        req_valid = 2'b01;
        #1;
        check_reset_outputs();
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", rsp_valid, 2'b00);
        end
        pair(1'b0);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
